// File: rtl/sseg_pkg.sv
// rtl/sseg_pkg.sv - shared constants for the seven-segment scan controller
package sseg_pkg;

   localparam int BRIGHT_W    = 4;

   // Bit positions inside the 8-bit cathode word {dp,g,f,e,d,c,b,a}
   localparam int CATH_DP     = 7;
   localparam int CATH_SEG_HI = 6;
   localparam int CATH_SEG_LO = 0;

   // Active-high {g..a} patterns; entry 0 is the rightmost slice
   localparam logic [15:0][6:0] SEG_LUT = {
      7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
      7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
   };

endpackage

// File: rtl/sseg_hex_decode.sv
// rtl/sseg_hex_decode.sv - nibble plus decimal point to active-high segment word
module sseg_hex_decode
   import sseg_pkg::*;
(
   input  logic [3:0] nibble,
   input  logic       dp,
   output logic [7:0] seg
);

   always_comb begin
      seg                          = '0;
      seg[CATH_SEG_HI:CATH_SEG_LO] = SEG_LUT[nibble];
      seg[CATH_DP]                 = dp;
   end

endmodule

// File: rtl/sseg_scan_mux.sv
// rtl/sseg_scan_mux.sv - N-digit multiplexed seven-segment driver with PWM,
// dead time, leading-zero suppression and per-slot input snapshot
module sseg_scan_mux
   import sseg_pkg::*;
#(
   parameter int N_DIGITS      = 4,
   parameter int REFRESH_DIV   = 100000,
   parameter bit ANODE_ACT_LOW = 1'b1,
   parameter bit CATH_ACT_LOW  = 1'b1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    en,
   input  logic [4*N_DIGITS-1:0]   hex,
   input  logic [N_DIGITS-1:0]     dp,
   input  logic [N_DIGITS-1:0]     blank,
   input  logic                    lz_en,
   input  logic [BRIGHT_W-1:0]     bright,
   output logic [N_DIGITS-1:0]     anode,
   output logic [7:0]              cathode
);

   localparam int CNT_W = $clog2(REFRESH_DIV + 1);
   localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
   localparam int STEP  = REFRESH_DIV / 16;

   localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(REFRESH_DIV - 1);
   localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(N_DIGITS - 1);
   localparam logic [N_DIGITS-1:0] AN_OFF   = {N_DIGITS{ANODE_ACT_LOW}};
   localparam logic [7:0]          CATH_OFF = {8{CATH_ACT_LOW}};

   logic [CNT_W-1:0]           div_cnt;
   logic [IDX_W-1:0]           dig_idx;

   logic [N_DIGITS-1:0][3:0]   hex_s;
   logic [N_DIGITS-1:0]        dp_s;
   logic [N_DIGITS-1:0]        blank_s;
   logic                       lz_en_s;
   logic [BRIGHT_W-1:0]        bright_s;

   logic [N_DIGITS-1:0]        supp;
   logic [N_DIGITS-1:0]        dark;
   logic                       seen;
   logic [CNT_W-1:0]           thr;
   logic                       slot_on;
   logic [N_DIGITS-1:0]        onehot;
   logic [7:0]                 seg_hi;

   always_ff @(posedge clk) begin
      if (reset || !en) begin
         div_cnt <= '0;
         dig_idx <= '0;
      end else if (div_cnt == CNT_LAST) begin
         div_cnt <= '0;
         dig_idx <= (dig_idx == IDX_LAST) ? '0 : dig_idx + 1'b1;
      end else begin
         div_cnt <= div_cnt + 1'b1;
      end
   end

   // Inputs are only sampled at slot start so a digit never tears mid-slot
   always_ff @(posedge clk) begin
      if (reset) begin
         hex_s    <= '0;
         dp_s     <= '0;
         blank_s  <= '0;
         lz_en_s  <= 1'b0;
         bright_s <= '0;
      end else if (en && div_cnt == '0) begin
         hex_s    <= hex;
         dp_s     <= dp;
         blank_s  <= blank;
         lz_en_s  <= lz_en;
         bright_s <= bright;
      end
   end

   // Zeros above the most significant nonzero nibble go dark; digit 0 always shows
   always_comb begin
      supp = '0;
      seen = 1'b0;
      for (int k = N_DIGITS - 1; k >= 1; k--) begin
         if (hex_s[k] != 4'h0)
            seen = 1'b1;
         supp[k] = lz_en_s && !seen;
      end
   end

   assign dark = blank_s | supp;
   assign thr  = CNT_W'((32'(bright_s) + 32'd1) * 32'(STEP));

   // Cycle 0 of every slot is dead time so the previous digit cannot ghost
   assign slot_on = en && (div_cnt != '0) && (div_cnt < thr) && !dark[dig_idx];

   always_comb begin
      onehot = '0;
      onehot[dig_idx] = 1'b1;
   end

   sseg_hex_decode u_dec (
      .nibble (hex_s[dig_idx]),
      .dp     (dp_s[dig_idx]),
      .seg    (seg_hi)
   );

   always_ff @(posedge clk) begin
      if (reset || !slot_on) begin
         anode   <= AN_OFF;
         cathode <= CATH_OFF;
      end else begin
         anode   <= onehot ^ AN_OFF;
         cathode <= seg_hi ^ CATH_OFF;
      end
   end

endmodule

// File: tb/tb_sseg_scan_mux.sv
// tb/tb_sseg_scan_mux.sv - scoreboard bench for sseg_scan_mux (4 digits, 16 clk per slot)
module tb_sseg_scan_mux;

   logic        clk = 1'b0;
   logic        reset;
   logic        en;
   logic [15:0] hex;
   logic [3:0]  dp;
   logic [3:0]  blank;
   logic        lz_en;
   logic [3:0]  bright;
   logic [3:0]  anode;
   logic [7:0]  cathode;

   always #5 clk = ~clk;

   sseg_scan_mux #(
      .N_DIGITS      (4),
      .REFRESH_DIV   (16),
      .ANODE_ACT_LOW (1'b1),
      .CATH_ACT_LOW  (1'b1)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .en      (en),
      .hex     (hex),
      .dp      (dp),
      .blank   (blank),
      .lz_en   (lz_en),
      .bright  (bright),
      .anode   (anode),
      .cathode (cathode)
   );

   localparam logic [11:0] IDLE = {4'hF, 8'hFF};

   logic [6:0]  seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
   logic [11:0] exp_q [$];
   int          n_assert = 0;
   int          n_fail   = 0;

   // Expected outputs for one full 4-digit frame starting from slot 0, cycle 0
   function automatic void push_frame(logic [15:0] h, logic [3:0] d, logic [3:0] b,
                                      logic lz, logic [3:0] br);
      logic [3:0] drk;
      logic       seen;
      logic       on;
      logic [3:0] sel;
      logic [3:0] nib;
      drk  = b;
      seen = 1'b0;
      for (int k = 3; k >= 1; k--) begin
         if (h[4*k +: 4] != 4'h0) seen = 1'b1;
         if (lz && !seen) drk[k] = 1'b1;
      end
      for (int g = 0; g < 4; g++) begin
         for (int c = 0; c < 16; c++) begin
            on  = (c >= 1) && (c <= int'(br)) && !drk[g];
            sel = 4'b0001 << g;
            nib = h[4*g +: 4];
            if (on) exp_q.push_back({~sel, ~{d[g], seg_tab[nib]}});
            else    exp_q.push_back(IDLE);
         end
      end
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [11:0] e);
      logic [11:0] obs;
      obs = {anode, cathode};
      n_assert++;
      assert (obs === e) else begin
         n_fail++;
         $error("FAIL %s: observed anode=%b cathode=%h expected anode=%b cathode=%h",
                tag, obs[11:8], obs[7:0], e[11:8], e[7:0]);
      end
   endtask

   task automatic run(input int n, input string tag);
      for (int i = 0; i < n; i++) begin
         step();
         if (exp_q.size() == 0) begin
            n_assert++;
            n_fail++;
            $error("FAIL %s: scoreboard empty, observed anode=%b cathode=%h expected queued entry",
                   tag, anode, cathode);
         end else begin
            check(tag, exp_q.pop_front());
         end
      end
   endtask

   task automatic set_in(input logic [15:0] h, input logic [3:0] d, input logic [3:0] b,
                         input logic lz, input logic [3:0] br);
      hex = h; dp = d; blank = b; lz_en = lz; bright = br;
   endtask

   initial begin
      reset = 1'b1;
      en    = 1'b1;
      set_in(16'h12AF, 4'h0, 4'h0, 1'b0, 4'd15);

      repeat (3) begin
         step();
         check("reset", IDLE);
      end
      reset = 1'b0;

      push_frame(16'h12AF, 4'h0, 4'h0, 1'b0, 4'd15);
      run(64, "full_bright");

      set_in(16'h12AF, 4'h0, 4'h0, 1'b0, 4'd3);
      push_frame(16'h12AF, 4'h0, 4'h0, 1'b0, 4'd3);
      run(64, "bright3");

      set_in(16'h12AF, 4'h0, 4'h0, 1'b0, 4'd0);
      push_frame(16'h12AF, 4'h0, 4'h0, 1'b0, 4'd0);
      run(64, "bright0");

      set_in(16'h00A0, 4'h0, 4'h0, 1'b1, 4'd15);
      push_frame(16'h00A0, 4'h0, 4'h0, 1'b1, 4'd15);
      run(64, "lz_00A0");

      set_in(16'h0000, 4'h0, 4'h0, 1'b1, 4'd15);
      push_frame(16'h0000, 4'h0, 4'h0, 1'b1, 4'd15);
      run(64, "lz_0000");

      set_in(16'h12AF, 4'b0100, 4'b0001, 1'b0, 4'd15);
      push_frame(16'h12AF, 4'b0100, 4'b0001, 1'b0, 4'd15);
      run(64, "dp_blank");

      // Mid-slot change must not reach digit 0 until its next slot
      set_in(16'h0001, 4'h0, 4'h0, 1'b0, 4'd15);
      push_frame(16'h0001, 4'h0, 4'h0, 1'b0, 4'd15);
      run(5, "tear_pre");
      hex = 16'h0009;
      run(59, "tear_hold");
      push_frame(16'h0009, 4'h0, 4'h0, 1'b0, 4'd15);
      run(64, "tear_new");

      push_frame(16'h0009, 4'h0, 4'h0, 1'b0, 4'd15);
      run(20, "en_pre");
      en = 1'b0;
      exp_q.delete();
      step();
      check("en_off", IDLE);
      step();
      check("en_off_hold", IDLE);
      set_in(16'h12AF, 4'h0, 4'h0, 1'b0, 4'd15);
      en = 1'b1;
      push_frame(16'h12AF, 4'h0, 4'h0, 1'b0, 4'd15);
      run(64, "re_enable");

      push_frame(16'h12AF, 4'h0, 4'h0, 1'b0, 4'd15);
      run(10, "rst_pre");
      reset = 1'b1;
      exp_q.delete();
      step();
      check("rst_mid", IDLE);
      reset = 1'b0;
      push_frame(16'h12AF, 4'h0, 4'h0, 1'b0, 4'd15);
      run(64, "after_rst");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
